// File: rtl/t2mi_pkg.sv
// Shared definitions for the T2-MI packet parser: packet types, header length,
// CRC-32/MPEG-2 constants, FSM encoding and a saturating counter helper.
package t2mi_pkg;

  localparam logic [7:0] T2MI_TYPE_BBF        = 8'h00;
  localparam logic [7:0] T2MI_TYPE_AUX_IQ     = 8'h01;
  localparam logic [7:0] T2MI_TYPE_L1_CURRENT = 8'h10;
  localparam logic [7:0] T2MI_TYPE_TIMESTAMP  = 8'h20;

  localparam int          T2MI_HDR_LEN = 6;
  localparam logic [31:0] CRC_POLY     = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC     = 3'd3,
    ST_END     = 3'd4
  } t2mi_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/crc32_mpeg2_byte.sv
// Combinational CRC-32/MPEG-2 update: advances the CRC register by one byte,
// MSB first, no reflection.
module crc32_mpeg2_byte
  import t2mi_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_c;

  always_comb begin
    w_c = i_crc;
    for (int b = 7; b >= 0; b--) begin
      if (w_c[31] ^ i_data[b]) w_c = {w_c[30:0], 1'b0} ^ CRC_POLY;
      else                     w_c = {w_c[30:0], 1'b0};
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/t2mi_packet_parser.sv
// T2-MI packet parser: frames the byte stream on sync, captures the 6-byte header,
// streams the payload out, checks CRC-32/MPEG-2 and the continuity counter.
module t2mi_packet_parser
  import t2mi_pkg::*;
#(
  parameter int MAX_PAYLOAD_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  t2mi_data,
  input  logic        t2mi_valid,
  input  logic        t2mi_sync,
  output logic        packet_start,
  output logic [7:0]  packet_type,
  output logic        packet_valid,
  output logic [7:0]  packet_data,
  output logic        packet_end,
  output logic [3:0]  superframe_idx,
  output logic        crc_error,
  output logic        length_error,
  output logic        framing_error,
  output logic        cc_error,
  output logic [15:0] pkt_ok_cnt,
  output logic [15:0] crc_err_cnt
);

  localparam logic [31:0] LP_MAX = 32'(MAX_PAYLOAD_BYTES);

  t2mi_state_e r_state, w_state_nxt;

  logic        w_sof, w_new_hdr, w_frm_err, w_hdr_last;
  logic        w_pay_byte, w_crc_byte, w_crc_last, w_crc_en;
  logic [2:0]  r_hdr_cnt;
  logic [7:0]  r_type, r_pkt_cnt, r_len_hi, r_cc_prev;
  logic [3:0]  r_sf;
  logic        r_cc_valid;
  logic [16:0] r_remain;
  logic [1:0]  r_crc_cnt;
  logic [31:0] r_crc, w_crc_seed, w_crc_nxt;
  logic [15:0] w_len;
  logic [16:0] w_nbytes;
  logic        w_too_long;

  assign w_sof      = t2mi_valid & t2mi_sync;
  assign w_len      = {r_len_hi, t2mi_data};
  // 17-bit sum so payload_len = 0xFFFF still rounds up without wrapping
  assign w_nbytes   = ({1'b0, w_len} + 17'd7) >> 3;
  assign w_too_long = 32'(w_nbytes) > LP_MAX;
  assign w_crc_seed = w_new_hdr ? CRC_INIT : r_crc;

  crc32_mpeg2_byte u_crc (
    .i_crc  (w_crc_seed),
    .i_data (t2mi_data),
    .o_crc  (w_crc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_new_hdr   = 1'b0;
    w_frm_err   = 1'b0;
    w_hdr_last  = 1'b0;
    w_pay_byte  = 1'b0;
    w_crc_byte  = 1'b0;
    w_crc_last  = 1'b0;
    w_crc_en    = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_END: begin
        w_state_nxt = ST_IDLE;
        if (w_sof) begin
          w_new_hdr   = 1'b1;
          w_crc_en    = 1'b1;
          w_state_nxt = ST_HEADER;
        end
      end
      ST_HEADER, ST_PAYLOAD, ST_CRC: begin
        if (w_sof) begin
          w_new_hdr   = 1'b1;
          w_frm_err   = 1'b1;
          w_crc_en    = 1'b1;
          w_state_nxt = ST_HEADER;
        end else if (t2mi_valid) begin
          w_crc_en = 1'b1;
          case (r_state)
            ST_HEADER: begin
              if (r_hdr_cnt == 3'(T2MI_HDR_LEN - 1)) begin
                w_hdr_last = 1'b1;
                if (w_too_long)             w_state_nxt = ST_IDLE;
                else if (w_nbytes == 17'd0) w_state_nxt = ST_CRC;
                else                        w_state_nxt = ST_PAYLOAD;
              end
            end
            ST_PAYLOAD: begin
              w_pay_byte = 1'b1;
              if (r_remain == 17'd1) w_state_nxt = ST_CRC;
            end
            default: begin
              w_crc_byte = 1'b1;
              if (r_crc_cnt == 2'd3) begin
                w_crc_last  = 1'b1;
                w_state_nxt = ST_END;
              end
            end
          endcase
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      packet_start   <= 1'b0;
      packet_type    <= 8'h00;
      packet_valid   <= 1'b0;
      packet_data    <= 8'h00;
      packet_end     <= 1'b0;
      superframe_idx <= 4'h0;
      crc_error      <= 1'b0;
      length_error   <= 1'b0;
      framing_error  <= 1'b0;
      cc_error       <= 1'b0;
      pkt_ok_cnt     <= 16'h0000;
      crc_err_cnt    <= 16'h0000;
      r_hdr_cnt      <= 3'd0;
      r_type         <= 8'h00;
      r_pkt_cnt      <= 8'h00;
      r_len_hi       <= 8'h00;
      r_sf           <= 4'h0;
      r_cc_prev      <= 8'h00;
      r_cc_valid     <= 1'b0;
      r_remain       <= 17'd0;
      r_crc_cnt      <= 2'd0;
      r_crc          <= 32'h0000_0000;
    end else begin
      packet_start  <= 1'b0;
      packet_valid  <= 1'b0;
      packet_end    <= 1'b0;
      crc_error     <= 1'b0;
      length_error  <= 1'b0;
      framing_error <= 1'b0;
      cc_error      <= 1'b0;

      if (w_crc_en) r_crc <= w_crc_nxt;

      if (w_new_hdr) begin
        r_hdr_cnt <= 3'd1;
        r_type    <= t2mi_data;
      end else if (r_state == ST_HEADER && t2mi_valid) begin
        r_hdr_cnt <= r_hdr_cnt + 3'd1;
        case (r_hdr_cnt)
          3'd1:    r_pkt_cnt <= t2mi_data;
          3'd2:    r_sf      <= t2mi_data[7:4];
          3'd4:    r_len_hi  <= t2mi_data;
          default: ;
        endcase
      end

      if (w_frm_err) begin
        framing_error <= 1'b1;
        r_cc_valid    <= 1'b0;
      end

      if (w_hdr_last) begin
        if (w_too_long) begin
          length_error <= 1'b1;
          r_cc_valid   <= 1'b0;
        end else begin
          packet_start   <= 1'b1;
          packet_type    <= r_type;
          superframe_idx <= r_sf;
          cc_error       <= r_cc_valid && (r_pkt_cnt != r_cc_prev + 8'd1);
          r_remain       <= w_nbytes;
          r_crc_cnt      <= 2'd0;
        end
      end

      if (w_pay_byte) begin
        packet_valid <= 1'b1;
        packet_data  <= t2mi_data;
        r_remain     <= r_remain - 17'd1;
      end

      if (w_crc_byte) r_crc_cnt <= r_crc_cnt + 2'd1;

      // residue after the 4 appended CRC bytes is zero for an intact packet
      if (w_crc_last) begin
        if (w_crc_nxt == 32'h0000_0000) begin
          packet_end <= 1'b1;
          pkt_ok_cnt <= sat_inc16(pkt_ok_cnt);
          r_cc_prev  <= r_pkt_cnt;
          r_cc_valid <= 1'b1;
        end else begin
          crc_error   <= 1'b1;
          crc_err_cnt <= sat_inc16(crc_err_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_t2mi_packet_parser.sv
// Scoreboard bench for t2mi_packet_parser: the driver queues expected output events
// with their cycle, and a negedge monitor pops and compares whenever the DUT emits one.
module tb_t2mi_packet_parser;
  import t2mi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  t2mi_data = 8'h00;
  logic        t2mi_valid = 1'b0;
  logic        t2mi_sync = 1'b0;
  logic        packet_start, packet_valid, packet_end;
  logic [7:0]  packet_type, packet_data;
  logic [3:0]  superframe_idx;
  logic        crc_error, length_error, framing_error, cc_error;
  logic [15:0] pkt_ok_cnt, crc_err_cnt;

  logic [31:0] tc_in = 32'h0;
  logic [7:0]  tc_d = 8'h0;
  logic [31:0] tc_out;

  t2mi_packet_parser #(.MAX_PAYLOAD_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n), .t2mi_data(t2mi_data), .t2mi_valid(t2mi_valid),
    .t2mi_sync(t2mi_sync), .packet_start(packet_start), .packet_type(packet_type),
    .packet_valid(packet_valid), .packet_data(packet_data), .packet_end(packet_end),
    .superframe_idx(superframe_idx), .crc_error(crc_error), .length_error(length_error),
    .framing_error(framing_error), .cc_error(cc_error), .pkt_ok_cnt(pkt_ok_cnt),
    .crc_err_cnt(crc_err_cnt)
  );

  crc32_mpeg2_byte u_crc_ref (.i_crc(tc_in), .i_data(tc_d), .o_crc(tc_out));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [6:0] F_START = 7'b1000000;
  localparam logic [6:0] F_VALID = 7'b0100000;
  localparam logic [6:0] F_END   = 7'b0010000;
  localparam logic [6:0] F_CRC   = 7'b0001000;
  localparam logic [6:0] F_LEN   = 7'b0000100;
  localparam logic [6:0] F_FRM   = 7'b0000010;
  localparam logic [6:0] F_CC    = 7'b0000001;

  typedef struct {
    int         cyc;
    logic [6:0] flags;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  gapmax = 0;
  int  ok_exp = 0;
  int  err_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_ev(input int c, input logic [6:0] f, input logic [7:0] d);
    ev_t e;
    e.cyc = c; e.flags = f; e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {b, 24'h0};
    for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    return r;
  endfunction

  // monitor: every cycle with any pulse or payload byte consumes one expected event
  always @(negedge clk) begin
    logic [6:0] f;
    logic [7:0] d;
    ev_t        e;
    f = {packet_start, packet_valid, packet_end, crc_error, length_error, framing_error, cc_error};
    d = packet_start ? packet_type : (packet_valid ? packet_data : 8'h00);
    if (f != 7'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event cycle=%0d flags=%b data=0x%0h required=none", cyc, f, d);
      end else begin
        e = exp_q.pop_front();
        chk("event_flags", 32'(f), 32'(e.flags));
        chk("event_data", 32'(d), 32'(e.data));
        chk("event_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic s, output int acc);
    int g;
    g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    repeat (g) begin
      t2mi_valid = 1'b0;
      t2mi_sync  = 1'b1;
      t2mi_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    t2mi_valid = 1'b1;
    t2mi_sync  = s;
    t2mi_data  = b;
    @(posedge clk);
    acc = cyc;
    #1;
    t2mi_valid = 1'b0;
    t2mi_sync  = 1'b0;
  endtask

  task automatic send_pkt(input logic [47:0] h, input int nb, input logic [7:0] base,
                          input bit bad, input bit exp_len, input bit exp_cc,
                          input bit exp_frm, input int stop_after);
    logic [31:0] crc, fcs;
    logic [7:0]  b;
    int          acc;
    crc = 32'hFFFF_FFFF;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      b = h[47-8*i -: 8];
      crc = crc_upd(crc, b);
      send_byte(b, i == 0, acc);
      if (i == 0 && exp_frm) push_ev(acc + 1, F_FRM, 8'h00);
    end
    if (exp_len) begin
      push_ev(acc + 1, F_LEN, 8'h00);
      return;
    end
    push_ev(acc + 1, exp_cc ? (F_START | F_CC) : F_START, h[47:40]);
    for (int i = 0; i < nb; i++) begin
      if (i == stop_after) return;
      b = base + 8'(i);
      crc = crc_upd(crc, b);
      send_byte(b, 1'b0, acc);
      push_ev(acc + 1, F_VALID, b);
    end
    fcs = crc;
    for (int i = 0; i < 4; i++) begin
      b = fcs[31-8*i -: 8];
      if (bad && i == 3) b = ~b;
      send_byte(b, 1'b0, acc);
    end
    if (bad) begin push_ev(acc + 1, F_CRC, 8'h00); err_exp++; end
    else     begin push_ev(acc + 1, F_END, 8'h00); ok_exp++;  end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    s = "123456789";
    tc_in = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) begin
      tc_d = s[i];
      #1;
      tc_in = tc_out;
    end
    chk("crc_check_123456789", tc_in, 32'h0376E6E7);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulses", 32'({packet_start, packet_valid, packet_end, crc_error,
                           length_error, framing_error, cc_error}), 32'h0);
    chk("rst_type", 32'(packet_type), 32'h0);
    chk("rst_data", 32'(packet_data), 32'h0);
    chk("rst_sf", 32'(superframe_idx), 32'h0);
    chk("rst_ok_cnt", 32'(pkt_ok_cnt), 32'h0);
    chk("rst_err_cnt", 32'(crc_err_cnt), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // timestamp packet, count 05, no gaps
    gapmax = 0;
    send_pkt(48'h20_05_00_00_00_60, 12, 8'h01, 0, 0, 0, 0, -1);
    @(negedge clk);
    chk("ok_cnt_after_first", 32'(pkt_ok_cnt), 32'(ok_exp));

    // count 06 with random valid gaps (sync high during gaps), superframe 3
    gapmax = 3;
    send_pkt(48'h20_06_30_00_00_60, 12, 8'h01, 0, 0, 0, 0, -1);
    @(negedge clk);
    chk("superframe_idx", 32'(superframe_idx), 32'h3);

    // count 08 skips 07: continuity error
    gapmax = 0;
    send_pkt(48'h20_08_00_00_00_60, 12, 8'h01, 0, 0, 1, 0, -1);
    repeat (3) @(negedge clk);
    chk("type_held", 32'(packet_type), 32'h20);

    // last CRC byte inverted
    send_pkt(48'h20_09_00_00_00_60, 12, 8'h01, 1, 0, 0, 0, -1);
    @(negedge clk);
    chk("crc_err_cnt", 32'(crc_err_cnt), 32'(err_exp));
    chk("ok_cnt_after_bad", 32'(pkt_ok_cnt), 32'(ok_exp));

    // 97 bits -> 13 bytes
    gapmax = 2;
    send_pkt(48'h01_09_00_00_00_61, 13, 8'h40, 0, 0, 0, 0, -1);

    // 0x8008 bits -> 4097 bytes: rejected
    gapmax = 0;
    send_pkt(48'h00_0A_00_00_80_08, 0, 8'h00, 0, 1, 0, 0, -1);

    // sync on payload byte 5 starts a new header
    send_pkt(48'h20_42_00_00_00_60, 12, 8'h01, 0, 0, 0, 0, 5);
    send_pkt(48'h20_77_00_00_00_10, 2, 8'hA0, 0, 0, 0, 1, -1);

    // zero-length payload goes straight to CRC
    send_pkt(48'h10_78_00_00_00_00, 0, 8'h00, 0, 0, 0, 0, -1);
    @(negedge clk);
    chk("ok_cnt_mid", 32'(pkt_ok_cnt), 32'(ok_exp));
    chk("crc_err_cnt_mid", 32'(crc_err_cnt), 32'(err_exp));

    // reset in the middle of a payload
    send_pkt(48'h20_10_00_00_00_60, 12, 8'h01, 0, 0, 1, 0, 3);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pulses", 32'({packet_start, packet_valid, packet_end, crc_error,
                                 length_error, framing_error, cc_error}), 32'h0);
    chk("async_rst_counters", {pkt_ok_cnt, crc_err_cnt}, 32'h0);
    chk("async_rst_type", 32'(packet_type), 32'h0);
    ok_exp = 0;
    err_exp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_pkt(48'h20_55_00_00_00_08, 1, 8'h5A, 0, 0, 0, 0, -1);

    repeat (5) @(posedge clk);
    #1;
    chk("final_ok_cnt", 32'(pkt_ok_cnt), 32'(ok_exp));
    chk("final_err_cnt", 32'(crc_err_cnt), 32'(err_exp));
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events actual=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
